// File: rtl/debug_spi_slave.sv
// Debug link front end on the MIPS clock: synchronizes the GPIO bus driven by the
// MicroBlaze and issues one read or write strobe per SCLK high pulse. It also
// derives the pipeline enable from the STEP and CONTINUE lines.
module debug_spi_slave #(
    parameter int unsigned NB_BITS = 32,
    parameter int unsigned NB_CS   = 4,
    parameter int unsigned NB_SYNC = 2
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_SCLK,
    input  logic [NB_CS-1:0]   i_SPI_cs,
    input  logic [NB_BITS-1:0] i_MOSI,
    input  logic               i_valid,
    input  logic               i_continue,
    input  logic [NB_BITS-1:0] i_rd_data,
    output logic               o_rd_req,
    output logic               o_wr_en,
    output logic [2:0]         o_sel,
    output logic [NB_BITS-1:0] o_wr_data,
    output logic [NB_BITS-1:0] o_MISO,
    output logic               o_busy,
    output logic               o_mips_en
);

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StCapture,
        StWrite,
        StWaitLow
    } state_t;

    // Synchronizer chains; index NB_SYNC-1 is the synchronized value.
    logic [NB_SYNC-1:0]              r_sclk_sync;
    logic [NB_SYNC-1:0]              r_valid_sync;
    logic [NB_SYNC-1:0]              r_cont_sync;
    logic [NB_SYNC-1:0][NB_CS-1:0]   r_cs_sync;
    logic [NB_SYNC-1:0][NB_BITS-1:0] r_mosi_sync;

    // Delayed copies for rising-edge detection.
    logic r_sclk_d;
    logic r_valid_d;

    logic               w_sclk;
    logic               w_sclk_rise;
    logic [NB_CS-1:0]   w_cs;
    logic [NB_BITS-1:0] w_mosi;
    logic               w_run;
    logic               w_step;

    state_t             r_state;
    state_t             w_state_next;
    logic               w_load;

    logic [2:0]         r_sel;
    logic [NB_BITS-1:0] r_wr_data;
    logic [NB_BITS-1:0] r_miso;

    // cs and MOSI use the same depth as SCLK so they line up with the detected edge.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_sclk_sync  <= '0;
            r_valid_sync <= '0;
            r_cont_sync  <= '0;
            r_cs_sync    <= '0;
            r_mosi_sync  <= '0;
            r_sclk_d     <= 1'b0;
            r_valid_d    <= 1'b0;
        end else begin
            r_sclk_sync  <= {r_sclk_sync[NB_SYNC-2:0], i_SCLK};
            r_valid_sync <= {r_valid_sync[NB_SYNC-2:0], i_valid};
            r_cont_sync  <= {r_cont_sync[NB_SYNC-2:0], i_continue};
            r_cs_sync    <= {r_cs_sync[NB_SYNC-2:0], i_SPI_cs};
            r_mosi_sync  <= {r_mosi_sync[NB_SYNC-2:0], i_MOSI};
            r_sclk_d     <= r_sclk_sync[NB_SYNC-1];
            r_valid_d    <= r_valid_sync[NB_SYNC-1];
        end
    end

    assign w_sclk      = r_sclk_sync[NB_SYNC-1];
    assign w_sclk_rise = w_sclk & ~r_sclk_d;
    assign w_cs        = r_cs_sync[NB_SYNC-1];
    assign w_mosi      = r_mosi_sync[NB_SYNC-1];
    assign w_run       = r_cont_sync[NB_SYNC-1];
    assign w_step      = r_valid_sync[NB_SYNC-1] & ~r_valid_d;

    // FSM state register.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; a null command still waits for SCLK low so one pulse is one request.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        case (r_state)
            StIdle: begin
                if (w_sclk_rise) begin
                    if (w_cs != '0) begin
                        w_load       = 1'b1;
                        w_state_next = w_cs[NB_CS-1] ? StWrite : StRead;
                    end else begin
                        w_state_next = StWaitLow;
                    end
                end
            end
            StRead:    w_state_next = StCapture;
            StCapture: w_state_next = StWaitLow;
            StWrite:   w_state_next = StWaitLow;
            StWaitLow: begin
                if (!w_sclk) begin
                    w_state_next = StIdle;
                end
            end
            default:   w_state_next = StIdle;
        endcase
    end

    // Command latch and read-result capture.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_sel     <= 3'd0;
            r_wr_data <= '0;
            r_miso    <= '0;
        end else begin
            if (w_load) begin
                r_sel     <= w_cs[2:0];
                r_wr_data <= w_mosi;
            end
            if (r_state == StCapture) begin
                r_miso <= i_rd_data;
            end
        end
    end

    // Strobes decode straight from the state register, so each lasts exactly one cycle.
    assign o_rd_req  = (r_state == StRead);
    assign o_wr_en   = (r_state == StWrite);
    assign o_busy    = (r_state != StIdle);
    assign o_sel     = r_sel;
    assign o_wr_data = r_wr_data;
    assign o_MISO    = r_miso;
    // A step during free-run is absorbed since the OR is already 1.
    assign o_mips_en = w_run | w_step;

endmodule

// File: tb/tb_debug_spi_slave.sv
// Bench for debug_spi_slave: expected strobes are queued as stimulus is driven and
// matched by a monitor as the DUT raises them.
module tb_debug_spi_slave;

    localparam int unsigned NB_BITS = 32;
    localparam int unsigned NB_CS   = 4;

    typedef struct packed {
        logic        wr;
        logic [2:0]  sel;
        logic [31:0] data;
    } strobe_t;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               sclk;
    logic [NB_CS-1:0]   cs;
    logic [NB_BITS-1:0] mosi;
    logic               valid;
    logic               cont;
    logic [NB_BITS-1:0] rd_data;
    logic               rd_req;
    logic               wr_en;
    logic [2:0]         sel;
    logic [NB_BITS-1:0] wr_data;
    logic [NB_BITS-1:0] miso;
    logic               busy;
    logic               mips_en;

    int n_checks = 0;
    int n_pass   = 0;
    strobe_t exp_q[$];

    debug_spi_slave #(
        .NB_BITS(NB_BITS),
        .NB_CS  (NB_CS),
        .NB_SYNC(2)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst_n),
        .i_SCLK    (sclk),
        .i_SPI_cs  (cs),
        .i_MOSI    (mosi),
        .i_valid   (valid),
        .i_continue(cont),
        .i_rd_data (rd_data),
        .o_rd_req  (rd_req),
        .o_wr_en   (wr_en),
        .o_sel     (sel),
        .o_wr_data (wr_data),
        .o_MISO    (miso),
        .o_busy    (busy),
        .o_mips_en (mips_en)
    );

    always #10 clk = ~clk;

    // Monitor: every strobe seen must match the oldest queued expectation.
    always @(negedge clk) begin
        strobe_t got;
        strobe_t want;
        if (rd_req === 1'b1 || wr_en === 1'b1) begin
            got = '{wr: wr_en, sel: sel, data: (wr_en === 1'b1) ? wr_data : 32'h0};
            n_checks++;
            if (rd_req === wr_en) begin
                $display("FAIL strobe_both rd=%0b wr=%0b want exactly one", rd_req, wr_en);
            end else if (exp_q.size() == 0) begin
                $display("FAIL strobe_unexpected got=%h want=none", got);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) $display("FAIL strobe_match got=%h want=%h", got, want);
                else n_pass++;
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "timeout");
    end

    // One transaction: cs/MOSI set a cycle ahead of SCLK, held until SCLK drops.
    task automatic transact(input logic [3:0] c, input logic [31:0] d, input int hi, input int lo);
        cs   = c;
        mosi = d;
        if (c != 4'd0) exp_q.push_back('{wr: c[3], sel: c[2:0], data: c[3] ? d : 32'h0});
        @(negedge clk);
        sclk = 1'b1;
        repeat (hi) @(negedge clk);
        sclk = 1'b0;
        repeat (lo - 1) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; sclk = 0; cs = 0; mosi = 0; valid = 0; cont = 0; rd_data = 0;
        repeat (3) @(negedge clk);
        n_checks++; if (rd_req !== 1'b0) $display("FAIL reset_rd_req got=%0b want=0", rd_req); else n_pass++;
        n_checks++; if (wr_en !== 1'b0) $display("FAIL reset_wr_en got=%0b want=0", wr_en); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%0b want=0", busy); else n_pass++;
        n_checks++; if (mips_en !== 1'b0) $display("FAIL reset_mips_en got=%0b want=0", mips_en); else n_pass++;
        n_checks++; if (sel !== 3'd0) $display("FAIL reset_sel got=%0d want=0", sel); else n_pass++;
        n_checks++; if (wr_data !== 32'h0) $display("FAIL reset_wr_data got=%h want=0", wr_data); else n_pass++;
        n_checks++; if (miso !== 32'h0) $display("FAIL reset_miso got=%h want=0", miso); else n_pass++;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_read();
        cs = 4'b0011; mosi = 0; rd_data = 32'hDEADBEEF;
        exp_q.push_back('{wr: 1'b0, sel: 3'd3, data: 32'h0});
        @(negedge clk);
        sclk = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);  // now just after edge k
            if (k == 1) begin
                n_checks++; if (rd_req !== 1'b0) $display("FAIL read_early_req got=%0b want=0", rd_req); else n_pass++;
                n_checks++; if (busy !== 1'b0) $display("FAIL read_early_busy got=%0b want=0", busy); else n_pass++;
            end else if (k == 2) begin
                n_checks++; if (rd_req !== 1'b1) $display("FAIL read_req_timing got=%0b want=1", rd_req); else n_pass++;
                n_checks++; if (busy !== 1'b1) $display("FAIL read_busy got=%0b want=1", busy); else n_pass++;
                n_checks++; if (sel !== 3'd3) $display("FAIL read_sel got=%0d want=3", sel); else n_pass++;
            end else if (k == 3) begin
                n_checks++; if (miso !== 32'h0) $display("FAIL read_miso_early got=%h want=0", miso); else n_pass++;
            end else if (k == 4) begin
                n_checks++; if (miso !== 32'hDEADBEEF) $display("FAIL read_miso got=%h want=deadbeef", miso); else n_pass++;
            end
        end
        repeat (100) @(negedge clk);
        n_checks++; if (busy !== 1'b1) $display("FAIL read_hold_busy got=%0b want=1", busy); else n_pass++;
        sclk = 1'b0;
        cs = 0;
        repeat (4) @(negedge clk);
        n_checks++; if (busy !== 1'b0) $display("FAIL read_idle_busy got=%0b want=0", busy); else n_pass++;
        n_checks++; if (exp_q.size() != 0) $display("FAIL read_pending got=%0d want=0", exp_q.size()); else n_pass++;
    endtask

    task automatic test_write();
        rd_data = 32'h55555555;
        transact(4'b1001, {7'd0, 25'h1ABCDEF}, 5, 5);
        cs = 0;
        n_checks++; if (wr_data !== 32'h01ABCDEF) $display("FAIL write_data got=%h want=01abcdef", wr_data); else n_pass++;
        n_checks++; if (sel !== 3'd1) $display("FAIL write_sel got=%0d want=1", sel); else n_pass++;
        n_checks++; if (miso !== 32'hDEADBEEF) $display("FAIL write_miso_kept got=%h want=deadbeef", miso); else n_pass++;
        n_checks++; if (exp_q.size() != 0) $display("FAIL write_pending got=%0d want=0", exp_q.size()); else n_pass++;
    endtask

    task automatic test_null();
        int busy_cycles = 0;
        cs = 4'd0; mosi = 32'h0;
        @(negedge clk);
        sclk = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (busy === 1'b1) busy_cycles++;
        end
        sclk = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (busy === 1'b1) busy_cycles++;
        end
        n_checks++; if (busy_cycles == 0) $display("FAIL null_busy_pulse got=%0d want>0", busy_cycles); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL null_idle got=%0b want=0", busy); else n_pass++;
        n_checks++; if (sel !== 3'd1) $display("FAIL null_sel_kept got=%0d want=1", sel); else n_pass++;
        rd_data = 32'h12345678;
        transact(4'b0101, 32'h0, 5, 4);
        cs = 0;
        n_checks++; if (miso !== 32'h12345678) $display("FAIL null_then_read got=%h want=12345678", miso); else n_pass++;
        n_checks++; if (exp_q.size() != 0) $display("FAIL null_pending got=%0d want=0", exp_q.size()); else n_pass++;
    endtask

    task automatic test_step_run();
        int hi_cycles = 0;
        int rises = 0;
        int lows = 0;
        logic prev = 1'b0;
        cont = 1'b0;
        repeat (3) @(negedge clk);
        for (int p = 0; p < 3; p++) begin
            valid = 1'b1;
            for (int k = 0; k < 7; k++) begin
                if (k == 3) valid = 1'b0;
                @(negedge clk);
                if (mips_en === 1'b1) hi_cycles++;
                if (mips_en === 1'b1 && !prev) rises++;
                prev = mips_en;
            end
        end
        n_checks++; if (hi_cycles != 3) $display("FAIL step_cycles got=%0d want=3", hi_cycles); else n_pass++;
        n_checks++; if (rises != 3) $display("FAIL step_pulses got=%0d want=3", rises); else n_pass++;
        cont = 1'b1;
        @(negedge clk);
        n_checks++; if (mips_en !== 1'b0) $display("FAIL run_latency_early got=%0b want=0", mips_en); else n_pass++;
        @(negedge clk);
        n_checks++; if (mips_en !== 1'b1) $display("FAIL run_latency got=%0b want=1", mips_en); else n_pass++;
        for (int k = 0; k < 12; k++) begin
            valid = (k >= 3 && k < 6);
            @(negedge clk);
            if (mips_en !== 1'b1) lows++;
        end
        n_checks++; if (lows != 0) $display("FAIL run_glitch got=%0d want=0", lows); else n_pass++;
        cont = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (mips_en !== 1'b0) $display("FAIL run_stop got=%0b want=0", mips_en); else n_pass++;
    endtask

    task automatic test_reset_mid_read();
        cs = 4'b0010; mosi = 0; rd_data = 32'hCAFEF00D;
        exp_q.push_back('{wr: 1'b0, sel: 3'd2, data: 32'h0});
        @(negedge clk);
        sclk = 1'b1;
        repeat (3) @(negedge clk);  // READ cycle
        n_checks++; if (rd_req !== 1'b1) $display("FAIL rst_mid_in_read got=%0b want=1", rd_req); else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (rd_req !== 1'b0) $display("FAIL rst_mid_rd_req got=%0b want=0", rd_req); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rst_mid_busy got=%0b want=0", busy); else n_pass++;
        n_checks++; if (miso !== 32'h0) $display("FAIL rst_mid_miso got=%h want=0", miso); else n_pass++;
        n_checks++; if (sel !== 3'd0) $display("FAIL rst_mid_sel got=%0d want=0", sel); else n_pass++;
        n_checks++; if (wr_data !== 32'h0) $display("FAIL rst_mid_wr_data got=%h want=0", wr_data); else n_pass++;
        sclk = 1'b0;
        cs = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        n_checks++; if (miso !== 32'h0) $display("FAIL rst_no_capture got=%h want=0", miso); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rst_release_idle got=%0b want=0", busy); else n_pass++;
        rd_data = 32'hBEEF0001;
        transact(4'b0110, 32'h0, 5, 4);
        cs = 0;
        n_checks++; if (miso !== 32'hBEEF0001) $display("FAIL rst_next_read got=%h want=beef0001", miso); else n_pass++;
        n_checks++; if (exp_q.size() != 0) $display("FAIL rst_pending got=%0d want=0", exp_q.size()); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int bad_miso = 0;
        for (int i = 0; i < 10; i++) begin
            logic [2:0]  s;
            logic [31:0] d;
            s = 3'((i % 7) + 1);
            d = $urandom & 32'h01FF_FFFF;
            if (i % 2 == 0) begin
                rd_data = $urandom;
                transact({1'b0, s}, 32'h0, 5, 3);
                if (miso !== rd_data) begin
                    bad_miso++;
                    $display("FAIL b2b_miso_%0d got=%h want=%h", i, miso, rd_data);
                end
            end else begin
                transact({1'b1, s}, d, 5, 3);
            end
        end
        cs = 0;
        repeat (4) @(negedge clk);
        n_checks++; if (bad_miso != 0) $display("FAIL b2b_miso_total got=%0d want=0", bad_miso); else n_pass++;
        n_checks++; if (exp_q.size() != 0) $display("FAIL b2b_pending got=%0d want=0", exp_q.size()); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL b2b_idle got=%0b want=0", busy); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_null();
        test_step_run();
        test_reset_mid_read();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/debug_spi_slave.md
# debug_spi_slave

MIPS-side front end of the debug link: it consumes the bit-banged GPIO bus driven by the MicroBlaze and turns it into single-cycle requests toward the MIPS debug register file and instruction memory. It sits between the GPIO pins of the soft processor and the MIPS debug unit, in the MIPS clock domain (50 MHz). It also turns the GPIO STEP and CONTINUE lines into a clean pipeline-enable. All GPIO inputs are asynchronous to `i_clk`.

## Interface
- `NB_BITS`, 32, width of the MOSI/MISO data words
- `NB_CS`, 4, width of the chip-select/command field
- `NB_SYNC`, 2, number of synchronizer flops on every GPIO input
- `i_clk`  in  1  MIPS clock; all logic is on its rising edge
- `i_rst`  in  1  reset; one clock, reset is asynchronous and active-low
- `i_SCLK`  in  1  GPIO transaction strobe; its rising edge starts a transaction
- `i_SPI_cs`  in  NB_CS  command: 0 = none, bit3 = 0 read, bit3 = 1 write; bits[2:0] select the target
- `i_MOSI`  in  NB_BITS  write data; upper 7 bits are always 0 from GPIO
- `i_valid`  in  1  STEP request; the rising edge requests one pipeline cycle
- `i_continue`  in  1  level; 1 = free-run
- `i_rd_data`  in  NB_BITS  read data from the debug unit, valid 1 cycle after `o_rd_req`
- `o_rd_req`  out  1  one-cycle read strobe
- `o_wr_en`  out  1  one-cycle write strobe
- `o_sel`  out  3  target select, latched `cs[2:0]`
- `o_wr_data`  out  NB_BITS  latched MOSI word
- `o_MISO`  out  NB_BITS  last read result, held until the next read completes
- `o_busy`  out  1  high from edge detection until return to IDLE
- `o_mips_en`  out  1  pipeline enable: `run` OR `step pulse`

## Operation
- Synchronization:
  - `i_SCLK`, `i_SPI_cs`, `i_MOSI`, `i_valid` and `i_continue` each pass through an `NB_SYNC`-flop synchronizer.
  - One extra flop on SCLK and on valid feeds the edge detection.
  - cs and MOSI use the same depth as SCLK, so they stay aligned with it. Software holds them stable before raising SCLK and until it lowers SCLK.
- FSM states: IDLE, READ, CAPTURE, WRITE, WAIT_LOW.
  - IDLE: on a synchronized SCLK rise with cs != 0, latch `cs[2:0]` into `o_sel` and MOSI into `o_wr_data`. Go to READ if `cs[3] = 0`, otherwise WRITE.
  - IDLE: a SCLK rise with cs = 0 goes to WAIT_LOW with no strobe.
  - READ: `o_rd_req` = 1 for this cycle only, then go to CAPTURE.
  - CAPTURE: `o_MISO <= i_rd_data`, then go to WAIT_LOW.
  - WRITE: `o_wr_en` = 1 for this cycle only, then go to WAIT_LOW.
  - WAIT_LOW: stay until synchronized SCLK = 0, then go to IDLE. Exactly one request is issued per SCLK high pulse.
- Execution control:
  - `run` is the synchronized `i_continue`.
  - A synchronized `i_valid` rise produces `step` = 1 for exactly one cycle.
  - A step that arrives while `run` = 1 is absorbed; `o_mips_en` simply stays 1.
  - Steps are independent of the FSM and may coincide with any transaction state.
- Width rule: `o_wr_data` is MOSI unmodified; zero-extension is done by the top level.
- Reset (async, while low): FSM = IDLE; all synchronizer and edge flops = 0; `o_rd_req` = `o_wr_en` = `o_busy` = `o_mips_en` = 0; `o_sel` = 0; `o_wr_data` = 0; `o_MISO` = 0. Reset in the middle of a transaction aborts it with no strobe.
- After reset is released with SCLK already high: the edge flops have reset to 0, so a rise is detected once the synchronizer fills. One transaction is executed. This is intended: software drives SCLK low before releasing reset.

## Timing
- Cycle count is measured from edge 0, the first `i_clk` edge that samples `i_SCLK` = 1 (with `NB_SYNC` = 2).
- Edge detection and state change to READ/WRITE occur at edge 2.
- `o_rd_req` or `o_wr_en` is high during the cycle after edge 2.
- `o_MISO` is updated at edge 4, i.e. 5 edges / 100 ns after SCLK rises. Software reads MISO no sooner than 1 µs after raising SCLK.
- `o_busy` is high from edge 2 until the cycle after synchronized SCLK = 0 is seen in WAIT_LOW.
- A SCLK pulse shorter than `NB_SYNC` + 1 cycles may be missed; this is not supported.
- `step`:
  - Pulse is high for exactly one cycle, 2 edges after `i_valid` rises.
  - `i_valid` must be low for at least 2 cycles before the next step.
- `o_mips_en` follows `i_continue` with 2 edges of latency.

## Test plan
- Read: cs = 4'b0011, raise SCLK -> exactly one `o_rd_req` with `o_sel` = 3. Bench returns `i_rd_data` = 32'hDEADBEEF -> `o_MISO` = DEADBEEF at edge 4; no second strobe while SCLK stays high for 100 cycles.
- Write: cs = 4'b1001, MOSI = 25'h1ABCDEF, SCLK pulse -> one `o_wr_en`, `o_sel` = 1, `o_wr_data` = 32'h01ABCDEF. `o_MISO` is unchanged.
- Null command: cs = 0 with a SCLK pulse -> no strobes, `o_busy` pulses, FSM returns to IDLE. A following read still works.
- Step/run: three `i_valid` pulses with continue = 0 -> exactly three one-cycle `o_mips_en` pulses. With continue = 1, `o_mips_en` is steady 1 and a step does not glitch it.
- Reset mid-read: assert `i_rst` = 0 in the READ cycle -> no capture, `o_MISO` = 0, all outputs 0. Release with SCLK low -> IDLE, and the next transaction is normal.
- Back-to-back: 10 alternating read/write transactions with SCLK low for 3 cycles between them -> exactly 10 strobes of the correct type and select.
